// File: rtl/fpga_mem_responder_if.sv
// Systolic-array request/response bus into the memory responder.
// The master issues reads/writes; the slave accepts them and returns read data.
interface fpga_mem_responder_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 12
);
  logic              sa_req;
  logic              sa_we;
  logic [ADDR_W-1:0] sa_addr;
  logic [WIDTH-1:0]  sa_wdata;
  logic              sa_ready;
  logic [WIDTH-1:0]  sa_rdata;
  logic              sa_rvalid;

  modport master (
    output sa_req, sa_we, sa_addr, sa_wdata,
    input  sa_ready, sa_rdata, sa_rvalid
  );

  modport slave (
    input  sa_req, sa_we, sa_addr, sa_wdata,
    output sa_ready, sa_rdata, sa_rvalid
  );
endinterface

// File: rtl/fpga_mem_responder.sv
// Single-port BRAM owner: arbitrates between systolic-array traffic and FPGA
// controller readback, handing ownership over through a one-cycle drain state.
module fpga_mem_responder #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    switch_mem_access,
  input  logic [ADDR_W-1:0]       addr_FPGA,
  output logic signed [WIDTH-1:0] mem_read,
  output logic                    mem_read_valid,
  output logic                    fpga_owner,
  fpga_mem_responder_if.slave     sa,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [WIDTH-1:0]        ram_wdata,
  input  logic [WIDTH-1:0]        ram_rdata
);

  typedef enum logic [1:0] {
    OWN_SA,
    DRAIN_TO_FPGA,
    OWN_FPGA,
    DRAIN_TO_SA
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t state_reg, state_next;
  logic   sw_reg;
  logic   toggle;

  logic   sa_in_range, fpga_in_range;
  logic   sa_ready_c, sa_accept;
  logic   fpga_issue, fpga_oor;

  logic   rd_pend_reg, rd_oor_reg;

  // Readback pipeline: s1 = BRAM data arriving, s2 = data sitting in mem_read.
  logic              fr_s1_vld_reg, fr_s1_oor_reg;
  logic [ADDR_W-1:0] fr_s1_addr_reg;
  logic              fr_s2_vld_reg;
  logic [ADDR_W-1:0] fr_s2_addr_reg;
  logic signed [WIDTH-1:0] mem_read_reg;

  assign toggle        = switch_mem_access && !sw_reg;
  assign sa_in_range   = {1'b0, sa.sa_addr} < DEPTH_L;
  assign fpga_in_range = {1'b0, addr_FPGA} < DEPTH_L;

  always_comb begin
    state_next = state_reg;
    sa_ready_c = 1'b0;
    sa_accept  = 1'b0;
    fpga_issue = 1'b0;
    fpga_oor   = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;

    case (state_reg)
      OWN_SA: begin
        // No request may be accepted on the cycle ownership starts to move.
        sa_ready_c = !toggle;
        sa_accept  = sa.sa_req && sa_ready_c;
        if (sa_accept) begin
          ram_en    = sa_in_range;
          ram_we    = sa.sa_we && sa_in_range;
          ram_addr  = sa.sa_addr;
          ram_wdata = sa.sa_wdata;
        end
        if (toggle) state_next = DRAIN_TO_FPGA;
      end
      DRAIN_TO_FPGA: state_next = OWN_FPGA;
      OWN_FPGA: begin
        fpga_issue = 1'b1;
        fpga_oor   = !fpga_in_range;
        ram_en     = fpga_in_range;
        ram_addr   = addr_FPGA;
        if (toggle) state_next = DRAIN_TO_SA;
      end
      DRAIN_TO_SA: state_next = OWN_SA;
      default:     state_next = OWN_SA;
    endcase

    // Combinational outputs must read as idle while reset is held.
    if (!rst) begin
      sa_ready_c = 1'b0;
      sa_accept  = 1'b0;
      fpga_issue = 1'b0;
      fpga_oor   = 1'b0;
      ram_en     = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = '0;
      ram_wdata  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= OWN_SA;
      sw_reg         <= 1'b0;
      rd_pend_reg    <= 1'b0;
      rd_oor_reg     <= 1'b0;
      fr_s1_vld_reg  <= 1'b0;
      fr_s1_oor_reg  <= 1'b0;
      fr_s1_addr_reg <= '0;
      fr_s2_vld_reg  <= 1'b0;
      fr_s2_addr_reg <= '0;
      mem_read_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      sw_reg         <= switch_mem_access;
      rd_pend_reg    <= sa_accept && !sa.sa_we;
      rd_oor_reg     <= !sa_in_range;
      fr_s1_vld_reg  <= fpga_issue;
      fr_s1_oor_reg  <= fpga_oor;
      fr_s1_addr_reg <= addr_FPGA;
      fr_s2_vld_reg  <= fr_s1_vld_reg;
      fr_s2_addr_reg <= fr_s1_addr_reg;
      // The last readback issued before a drain still lands here.
      if (fr_s1_vld_reg)
        mem_read_reg <= fr_s1_oor_reg ? '0 : $signed(ram_rdata);
    end
  end

  assign sa.sa_ready  = sa_ready_c;
  assign sa.sa_rvalid = rd_pend_reg;
  assign sa.sa_rdata  = (rd_pend_reg && !rd_oor_reg) ? ram_rdata : '0;

  assign fpga_owner     = (state_reg == OWN_FPGA);
  assign mem_read       = mem_read_reg;
  assign mem_read_valid = (state_reg == OWN_FPGA) && fr_s2_vld_reg
                          && (fr_s2_addr_reg == addr_FPGA);

endmodule

// File: tb/tb_fpga_mem_responder.sv
// Bench for fpga_mem_responder: BRAM model, table-driven SA and readback
// vectors, and a read-data scoreboard keyed on the expected delivery cycle.
module tb_fpga_mem_responder;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4000;

  logic                    clk;
  logic                    rst;
  logic                    switch_mem_access;
  logic [ADDR_W-1:0]       addr_FPGA;
  logic signed [WIDTH-1:0] mem_read;
  logic                    mem_read_valid;
  logic                    fpga_owner;
  logic                    ram_en;
  logic                    ram_we;
  logic [ADDR_W-1:0]       ram_addr;
  logic [WIDTH-1:0]        ram_wdata;
  logic [WIDTH-1:0]        ram_rdata;

  fpga_mem_responder_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) sa_bus ();

  fpga_mem_responder #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .switch_mem_access (switch_mem_access),
    .addr_FPGA         (addr_FPGA),
    .mem_read          (mem_read),
    .mem_read_valid    (mem_read_valid),
    .fpga_owner        (fpga_owner),
    .sa                (sa_bus),
    .ram_en            (ram_en),
    .ram_we            (ram_we),
    .ram_addr          (ram_addr),
    .ram_wdata         (ram_wdata),
    .ram_rdata         (ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Registered-read BRAM model.
  logic [WIDTH-1:0] bram [0:4095];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) bram[ram_addr] <= ram_wdata;
      else        ram_rdata      <= bram[ram_addr];
    end
  end

  typedef struct {
    logic [WIDTH-1:0] data;
    int               due;
  } sb_t;
  sb_t sb_q[$];
  logic [WIDTH-1:0] model_mem [0:4095];

  typedef struct {
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
    logic              exp_en;
    logic              exp_we;
  } sa_vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
    logic              exp_en;
  } fr_vec_t;

  sa_vec_t sa_vecs [12];
  fr_vec_t fr_vecs [5];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc_cnt, act, exp);
    end else begin
      $display("ok   %s @cyc %0d: %0h", name, cyc_cnt, act);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // Scoreboard: pushes expected read data on acceptance, pops on sa_rvalid.
  task automatic monitor();
    sb_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        sb_q.delete();
      end else begin
        if (sb_q.size() > 0 && sb_q[0].due < cyc_cnt) begin
          e = sb_q.pop_front();
          checks++;
          errors++;
          $display("FAIL sa_rvalid_missing @cyc %0d: got no rvalid, expected data %0h at cyc %0d",
                   cyc_cnt, e.data, e.due);
        end
        if (sa_bus.sa_rvalid) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sa_rvalid_unexpected @cyc %0d: got rvalid data %0h, expected no rvalid",
                     cyc_cnt, sa_bus.sa_rdata);
          end else begin
            e = sb_q.pop_front();
            if (e.due != cyc_cnt || sa_bus.sa_rdata !== e.data) begin
              errors++;
              $display("FAIL sa_rdata @cyc %0d: got %0h, expected %0h due cyc %0d",
                       cyc_cnt, sa_bus.sa_rdata, e.data, e.due);
            end else begin
              $display("ok   sa_rdata @cyc %0d: %0h", cyc_cnt, sa_bus.sa_rdata);
            end
          end
        end
        if (sa_bus.sa_req && sa_bus.sa_ready) begin
          if (sa_bus.sa_we) begin
            if (int'(sa_bus.sa_addr) < DEPTH) model_mem[sa_bus.sa_addr] = sa_bus.sa_wdata;
          end else begin
            e.data = (int'(sa_bus.sa_addr) < DEPTH) ? model_mem[sa_bus.sa_addr] : '0;
            e.due  = cyc_cnt + 1;
            sb_q.push_back(e);
          end
        end
      end
    end
  endtask

  initial begin
    sa_vecs[0]  = '{1'b1, 1'b1, 12'd5,    16'h0012, 1'b1, 1'b1};
    sa_vecs[1]  = '{1'b1, 1'b0, 12'd5,    16'h0000, 1'b1, 1'b0};
    sa_vecs[2]  = '{1'b1, 1'b1, 12'd1,    16'd10,   1'b1, 1'b1};
    sa_vecs[3]  = '{1'b1, 1'b1, 12'd2,    16'd20,   1'b1, 1'b1};
    sa_vecs[4]  = '{1'b1, 1'b1, 12'd3,    16'd30,   1'b1, 1'b1};
    sa_vecs[5]  = '{1'b1, 1'b1, 12'd7,    16'hFFFD, 1'b1, 1'b1};
    sa_vecs[6]  = '{1'b1, 1'b1, 12'd4000, 16'h1234, 1'b0, 1'b0};
    sa_vecs[7]  = '{1'b1, 1'b0, 12'd4000, 16'h0000, 1'b0, 1'b0};
    sa_vecs[8]  = '{1'b0, 1'b0, 12'd9,    16'h0000, 1'b0, 1'b0};
    sa_vecs[9]  = '{1'b1, 1'b0, 12'd2,    16'h0000, 1'b1, 1'b0};
    sa_vecs[10] = '{1'b1, 1'b0, 12'd3,    16'h0000, 1'b1, 1'b0};
    sa_vecs[11] = '{1'b0, 1'b1, 12'd3,    16'h5555, 1'b0, 1'b0};

    fr_vecs[0] = '{12'd1,    16'd10, 1'b1};
    fr_vecs[1] = '{12'd2,    16'd20, 1'b1};
    fr_vecs[2] = '{12'd3,    16'd30, 1'b1};
    fr_vecs[3] = '{12'd2,    16'd20, 1'b1};
    fr_vecs[4] = '{12'd4095, 16'd0,  1'b0};

    rst               = 1'b0;
    switch_mem_access = 1'b0;
    addr_FPGA         = 12'd1;
    sa_bus.sa_req     = 1'b0;
    sa_bus.sa_we      = 1'b0;
    sa_bus.sa_addr    = '0;
    sa_bus.sa_wdata   = '0;

    fork
      monitor();
    join_none

    // Reset: everything idle even with a request pending.
    cycle();
    cycle();
    sa_bus.sa_req = 1'b1;
    settle();
    check("rst_ram_en", 16'(ram_en), 16'd0);
    check("rst_sa_ready", 16'(sa_bus.sa_ready), 16'd0);
    check("rst_fpga_owner", 16'(fpga_owner), 16'd0);
    check("rst_mem_read", mem_read, 16'd0);
    check("rst_mem_read_valid", 16'(mem_read_valid), 16'd0);
    check("rst_sa_rvalid", 16'(sa_bus.sa_rvalid), 16'd0);

    // SA traffic in OWN_SA.
    for (int i = 0; i < 12; i++) begin
      cycle();
      rst             = 1'b1;
      sa_bus.sa_req   = sa_vecs[i].req;
      sa_bus.sa_we    = sa_vecs[i].we;
      sa_bus.sa_addr  = sa_vecs[i].addr;
      sa_bus.sa_wdata = sa_vecs[i].wdata;
      settle();
      check($sformatf("v%0d_sa_ready", i), 16'(sa_bus.sa_ready), 16'd1);
      check($sformatf("v%0d_ram_en", i), 16'(ram_en), 16'(sa_vecs[i].exp_en));
      check($sformatf("v%0d_ram_we", i), 16'(ram_we), 16'(sa_vecs[i].exp_we));
      if (sa_vecs[i].exp_en)
        check($sformatf("v%0d_ram_addr", i), 16'(ram_addr), 16'(sa_vecs[i].addr));
      if (sa_vecs[i].exp_we)
        check($sformatf("v%0d_ram_wdata", i), ram_wdata, sa_vecs[i].wdata);
    end

    // Read of addr 7 accepted, then toggle with a request that must be refused.
    cycle();
    sa_bus.sa_req  = 1'b1;
    sa_bus.sa_we   = 1'b0;
    sa_bus.sa_addr = 12'd7;
    settle();
    check("drain_rd7_ram_en", 16'(ram_en), 16'd1);
    cycle();
    switch_mem_access = 1'b1;
    sa_bus.sa_addr    = 12'd5;
    settle();
    check("toggle_sa_ready", 16'(sa_bus.sa_ready), 16'd0);
    check("toggle_ram_en", 16'(ram_en), 16'd0);
    check("toggle_fpga_owner", 16'(fpga_owner), 16'd0);
    cycle();
    switch_mem_access = 1'b0;
    settle();
    check("drain_fpga_ram_en", 16'(ram_en), 16'd0);
    check("drain_fpga_sa_ready", 16'(sa_bus.sa_ready), 16'd0);
    check("drain_fpga_owner", 16'(fpga_owner), 16'd0);

    // FPGA readback walk: right, right, right, left, then out of range.
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 10; k++) begin
        cycle();
        sa_bus.sa_req = 1'b0;
        addr_FPGA     = fr_vecs[i].addr;
        settle();
        if (k == 0) begin
          check($sformatf("fr%0d_owner", i), 16'(fpga_owner), 16'd1);
          check($sformatf("fr%0d_ram_en", i), 16'(ram_en), 16'(fr_vecs[i].exp_en));
          check($sformatf("fr%0d_ram_we", i), 16'(ram_we), 16'd0);
          check($sformatf("fr%0d_sa_ready", i), 16'(sa_bus.sa_ready), 16'd0);
        end
        if (k < 2)
          check($sformatf("fr%0d_valid_k%0d", i, k), 16'(mem_read_valid), 16'd0);
        if (k == 2 || k == 9) begin
          check($sformatf("fr%0d_valid_k%0d", i, k), 16'(mem_read_valid), 16'd1);
          check($sformatf("fr%0d_data_k%0d", i, k), mem_read, fr_vecs[i].data);
        end
      end
    end

    // Switch held high for 5 cycles: exactly one handoff back to SA.
    for (int h = 0; h < 6; h++) begin
      cycle();
      switch_mem_access = (h < 5);
      if (h == 0) addr_FPGA = 12'd2;
      settle();
      check($sformatf("hold%0d_owner", h), 16'(fpga_owner), (h == 0) ? 16'd1 : 16'd0);
      if (h == 1) check("hold_drain_ram_en", 16'(ram_en), 16'd0);
      if (h >= 2) check($sformatf("hold%0d_sa_ready", h), 16'(sa_bus.sa_ready), 16'd1);
      if (h == 2) begin
        check("hold_last_read_lands", mem_read, 16'd20);
        check("hold_valid_off", 16'(mem_read_valid), 16'd0);
      end
    end

    // Back to FPGA, then reset with a readback of addr 3 in flight.
    addr_FPGA = 12'd3;
    cycle();
    switch_mem_access = 1'b1;
    cycle();
    switch_mem_access = 1'b0;
    cycle();
    settle();
    check("pre_rst_owner", 16'(fpga_owner), 16'd1);
    cycle();
    rst            = 1'b0;
    sa_bus.sa_req  = 1'b1;
    sa_bus.sa_we   = 1'b0;
    sa_bus.sa_addr = 12'd5;
    settle();
    check("midrst_owner", 16'(fpga_owner), 16'd0);
    check("midrst_mem_read", mem_read, 16'd0);
    check("midrst_valid", 16'(mem_read_valid), 16'd0);
    check("midrst_ram_en", 16'(ram_en), 16'd0);
    cycle();
    cycle();
    rst           = 1'b1;
    sa_bus.sa_req = 1'b0;
    for (int r = 0; r < 3; r++) begin
      settle();
      check($sformatf("post_rst%0d_owner", r), 16'(fpga_owner), 16'd0);
      check($sformatf("post_rst%0d_sa_ready", r), 16'(sa_bus.sa_ready), 16'd1);
      check($sformatf("post_rst%0d_mem_read", r), mem_read, 16'd0);
      cycle();
    end

    // SA access works again after reset; stored data survives.
    sa_bus.sa_req  = 1'b1;
    sa_bus.sa_addr = 12'd5;
    settle();
    check("final_rd_ram_en", 16'(ram_en), 16'd1);
    cycle();
    sa_bus.sa_req = 1'b0;
    cycle();
    cycle();
    settle();
    check("sb_empty", 16'(sb_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
